// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock mode sequencer.
// Imported by alarm_mode_ctrl and its testbench.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_TIME  = 3'd1,
        ST_SET_ALARM = 3'd2,
        ST_RINGING   = 3'd3,
        ST_SNOOZE    = 3'd4
    } state_t;

    localparam logic DISP_TIME  = 1'b0;
    localparam logic DISP_ALARM = 1'b1;

    localparam int RING_SEC_DEF   = 60;
    localparam int SNOOZE_SEC_DEF = 300;

endpackage

// File: rtl/sec_down_counter.sv
// Loadable seconds down-counter, decrements on the 1 Hz tick, saturates at 0.
// o_zero_next flags the tick that takes the count from 1 to 0.
module sec_down_counter #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic [W-1:0] o_count,
    output logic         o_zero_next
);

    logic [W-1:0] r_count;

    // Load has priority, so a tick on the load cycle is not counted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count     = r_count;
    assign o_zero_next = i_tick && (r_count == W'(1));

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Mode sequencer: button routing, display select, alarm match,
// and the ring / snooze / dismiss sequence.
module alarm_mode_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = RING_SEC_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_1hz,
    input  logic       i_mode_btn,
    input  logic       i_snooze_btn,
    input  logic       i_alarm_arm,
    input  logic [5:0] i_time_hour,
    input  logic [5:0] i_time_min,
    input  logic [5:0] i_alarm_hour,
    input  logic [5:0] i_alarm_min,
    output logic       o_time_load_en,
    output logic       o_alarm_load_en,
    output logic       o_disp_sel,
    output logic       o_buzzer,
    output logic       o_blink,
    output logic [2:0] o_state_dbg
);

    localparam int MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CW      = $clog2(MAX_SEC + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_match_q;
    logic            r_blink;
    logic            w_match;
    logic            w_trig;
    logic            w_load;
    logic [CW-1:0]   w_load_val;
    logic [CW-1:0]   w_count;
    logic            w_zero_next;
    logic            w_expire;
    logic            w_dismiss;
    logic            w_blink_st;

    assign w_match   = (i_time_hour == i_alarm_hour) &&
                       (i_time_min == i_alarm_min);
    assign w_trig    = w_match && !r_match_q && i_alarm_arm;
    assign w_dismiss = i_mode_btn || !i_alarm_arm;
    assign w_expire  = w_zero_next && (w_count != '0);

    sec_down_counter #(.W(CW)) u_cnt (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .i_tick      (i_tick_1hz),
        .o_count     (w_count),
        .o_zero_next (w_zero_next)
    );

    // State register and match history; match_q resets high so a
    // match already present at reset does not ring.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_RUN;
            r_match_q <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_match_q <= w_match;
        end
    end

    // Next-state logic and counter load requests.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = CW'(RING_SEC);
        unique case (r_state)
            ST_RUN: begin
                if (w_trig) begin
                    w_next = ST_RINGING;
                    w_load = 1'b1;
                end else if (i_mode_btn) begin
                    w_next = ST_SET_TIME;
                end
            end
            ST_SET_TIME: begin
                if (i_mode_btn) w_next = ST_SET_ALARM;
            end
            ST_SET_ALARM: begin
                if (i_mode_btn) w_next = ST_RUN;
            end
            ST_RINGING: begin
                if (w_dismiss) begin
                    w_next = ST_RUN;
                end else if (i_snooze_btn) begin
                    w_next     = ST_SNOOZE;
                    w_load     = 1'b1;
                    w_load_val = CW'(SNOOZE_SEC);
                end else if (w_expire) begin
                    w_next = ST_RUN;
                end
            end
            ST_SNOOZE: begin
                if (w_dismiss) begin
                    w_next = ST_RUN;
                end else if (w_expire) begin
                    w_next = ST_RINGING;
                    w_load = 1'b1;
                end
            end
            default: w_next = ST_RUN;
        endcase
    end

    // Blink toggles on ticks in the editing and ringing states and is
    // cleared on every state change.
    always_comb begin
        w_blink_st = (r_state == ST_SET_TIME) ||
                     (r_state == ST_SET_ALARM) ||
                     (r_state == ST_RINGING);
    end

    // Blink toggle flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_blink <= 1'b0;
        end else if (w_next != r_state) begin
            r_blink <= 1'b0;
        end else if (!w_blink_st) begin
            r_blink <= 1'b0;
        end else if (i_tick_1hz) begin
            r_blink <= ~r_blink;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        o_time_load_en  = 1'b0;
        o_alarm_load_en = 1'b0;
        o_disp_sel      = DISP_TIME;
        o_buzzer        = 1'b0;
        unique case (r_state)
            ST_SET_TIME:  o_time_load_en = 1'b1;
            ST_SET_ALARM: begin
                o_alarm_load_en = 1'b1;
                o_disp_sel      = DISP_ALARM;
            end
            ST_RINGING:   o_buzzer = 1'b1;
            default:      ;
        endcase
    end

    assign o_blink     = r_blink;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Scoreboard bench for alarm_mode_ctrl with short ring/snooze times.
// Expected outputs are queued with each stimulus cycle.
module tb_alarm_mode_ctrl;

    localparam logic [7:0] E_RUN  = 8'h00;
    localparam logic [7:0] E_ST   = 8'h81;
    localparam logic [7:0] E_STB  = 8'h89;
    localparam logic [7:0] E_SA   = 8'h62;
    localparam logic [7:0] E_SAB  = 8'h6A;
    localparam logic [7:0] E_RG   = 8'h13;
    localparam logic [7:0] E_RGB  = 8'h1B;
    localparam logic [7:0] E_SN   = 8'h04;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       mode;
    logic       snz;
    logic       arm;
    logic [5:0] th;
    logic [5:0] tm;
    logic [5:0] ah;
    logic [5:0] am;
    logic       tl_en;
    logic       al_en;
    logic       dsel;
    logic       buz;
    logic       blk;
    logic [2:0] st;

    logic       v_arm;
    logic [5:0] v_th;
    logic [5:0] v_tm;

    sb_t sb_q[$];
    int  n_vec;
    int  n_err;

    alarm_mode_ctrl #(
        .RING_SEC   (4),
        .SNOOZE_SEC (3)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_tick_1hz      (tick),
        .i_mode_btn      (mode),
        .i_snooze_btn    (snz),
        .i_alarm_arm     (arm),
        .i_time_hour     (th),
        .i_time_min      (tm),
        .i_alarm_hour    (ah),
        .i_alarm_min     (am),
        .o_time_load_en  (tl_en),
        .o_alarm_load_en (al_en),
        .o_disp_sel      (dsel),
        .o_buzzer        (buz),
        .o_blink         (blk),
        .o_state_dbg     (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h (tl,al,ds,bz,bl,st) exp %h",
                     tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic m,
                       input logic s, input logic t, input logic [7:0] e);
        sb_t x;
        @(negedge clk);
        reset = r;
        mode  = m;
        snz   = s;
        tick  = t;
        arm   = v_arm;
        th    = v_th;
        tm    = v_tm;
        x.tag = tag;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    always @(posedge clk) begin
        sb_t x;
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk(x.tag, {tl_en, al_en, dsel, buz, blk, st}, x.exp);
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        tick  = 1'b0;
        mode  = 1'b0;
        snz   = 1'b0;
        arm   = 1'b1;
        ah    = 6'd7;
        am    = 6'd30;
        v_arm = 1'b1;
        v_th  = 6'd0;
        v_tm  = 6'd0;
        th    = 6'd0;
        tm    = 6'd0;

        cyc("reset", 1, 0, 0, 0, E_RUN);
        cyc("idle", 0, 0, 0, 0, E_RUN);

        cyc("mode1", 0, 1, 0, 0, E_ST);
        cyc("st_tick1", 0, 0, 0, 1, E_STB);
        cyc("st_tick2", 0, 0, 0, 1, E_ST);
        cyc("st_tick3", 0, 0, 0, 1, E_STB);
        cyc("mode2", 0, 1, 0, 0, E_SA);
        cyc("sa_tick", 0, 0, 0, 1, E_SAB);
        cyc("mode3", 0, 1, 0, 0, E_RUN);
        cyc("run_tick", 0, 0, 0, 1, E_RUN);

        v_th = 6'd7; v_tm = 6'd29;
        cyc("pre_match", 0, 0, 0, 0, E_RUN);
        v_tm = 6'd30;
        cyc("trig", 0, 0, 0, 0, E_RG);
        cyc("dismiss", 0, 1, 0, 0, E_RUN);
        cyc("hold1", 0, 0, 0, 0, E_RUN);
        cyc("hold2", 0, 0, 0, 1, E_RUN);
        v_tm = 6'd31;
        cyc("leave", 0, 0, 0, 0, E_RUN);
        v_tm = 6'd30;
        cyc("retrig", 0, 0, 0, 0, E_RG);
        cyc("dismiss2", 0, 1, 0, 0, E_RUN);

        v_tm = 6'd31;
        cyc("ad_pre", 0, 0, 0, 0, E_RUN);
        v_tm = 6'd30;
        cyc("ad_trig_tick", 0, 0, 0, 1, E_RG);
        cyc("ad_t1", 0, 0, 0, 1, E_RGB);
        cyc("ad_t2", 0, 0, 0, 1, E_RG);
        cyc("ad_t3", 0, 0, 0, 1, E_RGB);
        cyc("ad_gap", 0, 0, 0, 0, E_RGB);
        cyc("ad_t4", 0, 0, 0, 1, E_RUN);
        cyc("ad_after", 0, 0, 0, 0, E_RUN);

        v_tm = 6'd31;
        cyc("sn_pre", 0, 0, 0, 0, E_RUN);
        v_tm = 6'd30;
        cyc("sn_trig", 0, 0, 0, 0, E_RG);
        cyc("snooze", 0, 0, 1, 0, E_SN);
        cyc("snz_ign", 0, 0, 1, 0, E_SN);
        cyc("sn_t1", 0, 0, 0, 1, E_SN);
        cyc("sn_t2", 0, 0, 0, 1, E_SN);
        cyc("sn_t3", 0, 0, 0, 1, E_RG);
        cyc("rering_t", 0, 0, 0, 1, E_RGB);
        cyc("sn_mode", 0, 1, 0, 0, E_RUN);

        v_tm = 6'd29;
        cyc("mk_pre", 0, 0, 0, 0, E_RUN);
        cyc("mk_st", 0, 1, 0, 0, E_ST);
        v_tm = 6'd30;
        cyc("mk_cross", 0, 0, 0, 0, E_ST);
        cyc("mk_sa", 0, 1, 0, 0, E_SA);
        cyc("mk_run", 0, 1, 0, 0, E_RUN);
        cyc("mk_hold", 0, 0, 0, 0, E_RUN);

        v_tm = 6'd31;
        cyc("pr_pre", 0, 0, 0, 0, E_RUN);
        v_tm = 6'd30;
        cyc("trig_vs_mode", 0, 1, 0, 0, E_RG);
        cyc("ring_reset", 1, 0, 0, 0, E_RUN);
        cyc("post_reset", 0, 0, 0, 1, E_RUN);

        v_tm = 6'd31;
        cyc("ar_pre", 0, 0, 0, 0, E_RUN);
        v_tm = 6'd30;
        cyc("ar_trig", 0, 0, 0, 0, E_RG);
        cyc("ar_snooze", 0, 0, 1, 0, E_SN);
        v_arm = 1'b0;
        cyc("arm_drop", 0, 0, 0, 0, E_RUN);
        for (int i = 0; i < 4; i++) begin
            cyc("no_rering", 0, 0, 0, 1, E_RUN);
        end
        v_arm = 1'b1;
        cyc("rearm_hold", 0, 0, 0, 0, E_RUN);

        v_tm = 6'd31;
        cyc("rd_pre", 0, 0, 0, 0, E_RUN);
        v_tm = 6'd30;
        cyc("rd_trig", 0, 0, 0, 0, E_RG);
        v_arm = 1'b0;
        cyc("ring_disarm", 0, 0, 0, 0, E_RUN);
        v_arm = 1'b1;
        cyc("end_idle", 0, 0, 0, 0, E_RUN);

        @(posedge clk);
        #3;
        chk("sb_drain", 8'(sb_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_mode_ctrl.md
# alarm_mode_ctrl

Top-level mode sequencer for the alarm clock. It decides whether the time loader or the alarm loader receives the user buttons, selects which value feeds the seven-segment LUT/number path, and detects the alarm match. It also runs the ring, snooze and dismiss sequence against the 1 Hz tick, and sits between the debounced buttons, the two loader instances and the display path.

## Interface
- `RING_SEC`, default 60: ring duration in 1 Hz ticks before auto-dismiss.
- `SNOOZE_SEC`, default 300: snooze duration in ticks before re-ring.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high.
- `tick_1hz`  in  1  single-cycle pulse, once per second.
- `mode_btn`  in  1  debounced single-cycle pulse.
- `snooze_btn`  in  1  debounced single-cycle pulse.
- `alarm_arm`  in  1  level switch; 1 = alarm armed.
- `time_hour`  in  6  running hour, 0–23.
- `time_min`  in  6  running minute, 0–59.
- `alarm_hour`  in  6  alarm loader hour.
- `alarm_min`  in  6  alarm loader minute.
- `time_load_en`  out  1  enable for the time loader.
- `alarm_load_en`  out  1  enable for the alarm loader.
- `disp_sel`  out  1  display source: 0 = running time, 1 = alarm value.
- `buzzer`  out  1  alarm sound.
- `blink`  out  1  display blank toggle.
- `state_dbg`  out  3  current state encoding.

## Operation
- States: RUN=0, SET_TIME=1, SET_ALARM=2, RINGING=3, SNOOZE=4. All outputs are Moore-decoded from the state register.
- Output decode by state:
  - RUN: all 0, except `disp_sel`=0.
  - SET_TIME: `time_load_en`=1, `disp_sel`=0.
  - SET_ALARM: `alarm_load_en`=1, `disp_sel`=1.
  - RINGING: `buzzer`=1, `disp_sel`=0.
  - SNOOZE: `disp_sel`=0, `buzzer`=0.
- `blink` is a toggle flop. It flips on each `tick_1hz` in SET_TIME, SET_ALARM and RINGING, and is forced to 0 in every other state and on each state change.
- `match` = (`time_hour`==`alarm_hour`) && (`time_min`==`alarm_min`).
- `match_q` registers `match` every cycle, in all states.
- `trig` = `match` && !`match_q` && `alarm_arm`. This is a rising-edge trigger, so there is no retrigger within the same minute after a dismiss.
- Transitions:
  - RUN: `mode_btn` → SET_TIME. `trig` → RINGING. If both occur in the same cycle, `trig` wins.
  - SET_TIME: `mode_btn` → SET_ALARM. `trig` is ignored; `match_q` still updates, so there is no late trigger on return.
  - SET_ALARM: `mode_btn` → RUN. `trig` is ignored.
  - RINGING: priority order (highest first):
    1. `mode_btn` or !`alarm_arm` → RUN (dismiss).
    2. `snooze_btn` → SNOOZE, with counter loaded to `SNOOZE_SEC`.
    3. counter reaching 0 on a tick → RUN.
  - SNOOZE: priority order (highest first):
    1. `mode_btn` or !`alarm_arm` → RUN.
    2. counter reaching 0 on a tick → RINGING, with counter loaded to `RING_SEC`.
    3. `snooze_btn` is ignored.
- Counter:
  - A single down-counter is shared by RINGING and SNOOZE.
  - Width is clog2(max(`RING_SEC`, `SNOOZE_SEC`)+1).
  - It is loaded to `RING_SEC` on entry to RINGING from RUN or SNOOZE.
  - It decrements only on `tick_1hz` and saturates at 0.
  - The exit fires on the tick at which the count is 1 and is about to reach 0. The ring therefore lasts exactly `RING_SEC` ticks.
- Comparison is unsigned 6-bit with no format conversion. 12/24 h decoding stays downstream.

## Timing
- Reset values: state=RUN, counter=0, `match_q`=1.
  - Reset `match_q` to 1 so that a match already present at reset does not ring.
  - All outputs are 0 during and after reset.
- Input pulse in cycle N → new state and outputs valid from cycle N+1 (1-cycle latency).
- `trig` in cycle N → `buzzer`=1 from cycle N+1.
- `reset` during RINGING or SNOOZE → RUN next cycle with `buzzer`=0, and the counter is cleared.
- `alarm_arm` dropping mid-SNOOZE → RUN next cycle. No pending re-ring is kept.
- `tick_1hz` in the same cycle as the RINGING entry is not counted.

## Structure
- Shared package `alarm_pkg` holds:
  - the state enum (3-bit encodings above);
  - `DISP_TIME`=0 and `DISP_ALARM`=1;
  - the default `RING_SEC` and `SNOOZE_SEC`.
- One sub-module, `sec_down_counter`:
  - parameterised width;
  - ports: load, load value, tick, count, `zero_next` flag.
- The FSM and match logic live in `alarm_mode_ctrl`.

## Test plan
- Mode cycling: reset, then pulse `mode_btn` ×3 → `state_dbg` 0→1→2→0. `time_load_en` is high only in state 1; `alarm_load_en` and `disp_sel` are high only in state 2.
- Alarm trigger: alarm=07:30, arm=1, time steps 07:29→07:30 → `buzzer`=1 one cycle later. Hold 07:30 and dismiss → no re-ring until the time leaves 07:30 and returns.
- Auto-dismiss: `RING_SEC`=4, trigger, then 4 `tick_1hz` pulses → `buzzer` falls on the cycle after the 4th tick, state=RUN.
- Snooze: `SNOOZE_SEC`=3, trigger, `snooze_btn` → `buzzer`=0. 3 ticks later → RINGING with `buzzer`=1 again. `mode_btn` then → RUN.
- Masked trigger: enter SET_TIME, time crosses the alarm value → no RINGING. Return to RUN still inside the matching minute → no ring.
- Reset and arm: `reset` during RINGING → all outputs 0 next cycle. Separately, `alarm_arm`=0 during SNOOZE → RUN next cycle, and no ring follows.
